// File: rtl/add_sum_ram_mc.sv
// rtl/add_sum_ram_mc.sv - multi-lane read-modify-write accumulator RAM with hazard forwarding
// Define ADD_SUM_RAM_SAT_EN to saturate lane sums instead of wrapping (drives O_sat).
`timescale 1ns/1ps
module add_sum_ram_mc #(
    parameter string C_MEM_STYLE = "block",
    parameter int    C_CH        = 4,
    parameter int    C_ISIZE     = 12,
    parameter int    C_DSIZE     = 24,
    parameter int    C_ASIZE     = 10
) (
    input  logic                       I_clk,
    input  logic                       I_rst,
    input  logic                       I_din_valid,
    input  logic                       I_first_flag,
    input  logic [C_ASIZE-1:0]         I_waddr,
    input  logic [C_CH*C_ISIZE-1:0]    I_din,
    input  logic                       I_rd_en,
    input  logic [C_ASIZE-1:0]         I_raddr,
    output logic                       O_rd_ack,
    output logic                       O_rdata_valid,
    output logic [C_CH*C_DSIZE-1:0]    O_rdata,
    output logic [C_CH-1:0]            O_sat
);

    localparam int W     = C_CH*C_DSIZE;
    localparam int DEPTH = 1 << C_ASIZE;

    (* ram_style = C_MEM_STYLE *) logic [W-1:0] mem [DEPTH];

    logic [C_ASIZE-1:0]      ram_raddr;
    logic [W-1:0]            ram_dout;

    logic                    s1_acc, s1_rd, s1_first;
    logic [C_ASIZE-1:0]      s1_addr;
    logic [C_CH*C_ISIZE-1:0] s1_din;

    logic                    w1_valid, w2_valid;
    logic [C_ASIZE-1:0]      w1_addr, w2_addr;
    logic [W-1:0]            w1_data, w2_data;

    logic [W-1:0]            fwd_data;
    logic [W-1:0]            sum_data;

    // Accumulates own the single read port; external reads only get idle cycles.
    assign O_rd_ack  = I_rd_en & ~I_din_valid;
    assign ram_raddr = I_din_valid ? I_waddr : I_raddr;

    always_ff @(posedge I_clk) begin
        if (w1_valid) begin
            mem[w1_addr] <= w1_data;
        end
        ram_dout <= mem[ram_raddr];
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            s1_acc   <= 1'b0;
            s1_rd    <= 1'b0;
            s1_first <= 1'b0;
            s1_addr  <= '0;
            s1_din   <= '0;
        end else begin
            s1_acc   <= I_din_valid;
            s1_rd    <= O_rd_ack;
            s1_first <= I_first_flag;
            s1_addr  <= I_din_valid ? I_waddr : I_raddr;
            s1_din   <= I_din;
        end
    end

    // Newest pending write wins, so RAM read-during-write behaviour never matters.
    always_comb begin
        fwd_data = ram_dout;
        if (w1_valid && (w1_addr == s1_addr)) begin
            fwd_data = w1_data;
        end else if (w2_valid && (w2_addr == s1_addr)) begin
            fwd_data = w2_data;
        end
    end

`ifdef ADD_SUM_RAM_SAT_EN
    logic [C_CH-1:0] sum_sat;
    logic [C_CH-1:0] w1_sat;
`endif

    for (genvar k = 0; k < C_CH; k++) begin : g_lane
        logic signed [C_DSIZE-1:0] old_v;
        logic signed [C_DSIZE-1:0] ext_v;
        logic signed [C_DSIZE-1:0] sum_v;

        assign old_v = fwd_data[k*C_DSIZE +: C_DSIZE];
        assign ext_v = C_DSIZE'($signed(s1_din[k*C_ISIZE +: C_ISIZE]));

`ifdef ADD_SUM_RAM_SAT_EN
        logic signed [C_DSIZE:0] wide_v;
        logic                    ovf_v;

        // One guard bit: overflow iff the two top bits of the wide sum disagree.
        assign wide_v = {old_v[C_DSIZE-1], old_v} + {ext_v[C_DSIZE-1], ext_v};
        assign ovf_v  = ~s1_first & (wide_v[C_DSIZE] ^ wide_v[C_DSIZE-1]);
        assign sum_v  = s1_first ? ext_v :
                        ~ovf_v   ? wide_v[C_DSIZE-1:0] :
                        wide_v[C_DSIZE] ? {1'b1, {(C_DSIZE-1){1'b0}}} :
                                          {1'b0, {(C_DSIZE-1){1'b1}}};
        assign sum_sat[k] = ovf_v;
`else
        assign sum_v = s1_first ? ext_v : old_v + ext_v;
`endif

        assign sum_data[k*C_DSIZE +: C_DSIZE] = sum_v;
    end

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            w1_valid      <= 1'b0;
            w1_addr       <= '0;
            w1_data       <= '0;
            w2_valid      <= 1'b0;
            w2_addr       <= '0;
            w2_data       <= '0;
            O_rdata_valid <= 1'b0;
            O_rdata       <= '0;
        end else begin
            w1_valid      <= s1_acc;
            w1_addr       <= s1_addr;
            w1_data       <= sum_data;
            w2_valid      <= w1_valid;
            w2_addr       <= w1_addr;
            w2_data       <= w1_data;
            O_rdata_valid <= s1_rd;
            if (s1_rd) begin
                O_rdata <= fwd_data;
            end
        end
    end

`ifdef ADD_SUM_RAM_SAT_EN
    // Pulses while the clamped value sits in W1, i.e. the cycle it is written.
    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            w1_sat <= '0;
        end else begin
            w1_sat <= s1_acc ? sum_sat : '0;
        end
    end
    assign O_sat = w1_sat;
`else
    assign O_sat = '0;
`endif

endmodule
